// File: rtl/compressor_bench_pkg.sv
// Shared constants and helpers for the compressor bench load/unload stages.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: FSM state encodings (S_IDLE, S_SHIFT, S_DONE), default result
// width, and a helper that sizes a bit counter able to hold 0..w.
package compressor_bench_pkg;

    // Default number of compressor result bits.
    localparam int DEFAULT_WIDTH = 19;

    // FSM state encodings (plain constants so older tools can consume them).
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    // Width of a counter that must represent every value from 0 to w.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/result_serializer.sv
// Parallel-to-serial unload of the compressor result, streamed LSB-first.
// Latency: first bit valid the cycle after start; done pulses one cycle after the last accepted bit.
// Backpressure: ser_out/ser_valid hold while ser_ready is low; start is ignored while busy.
//
// Ports:
//   i_clk        rising-edge clock
//   i_rst        synchronous active-high reset (aborts any transfer, no done)
//   i_dst        parallel result, bit i = dst<i>, sampled only on an IDLE start
//   i_start      capture i_dst and begin a transfer
//   o_busy       high in SHIFT and DONE
//   o_ser_out    current serial bit (0 when not shifting)
//   o_ser_valid  o_ser_out holds a valid bit
//   i_ser_ready  downstream accepts o_ser_out this cycle
//   o_done       one-cycle pulse after the final bit is accepted
//
// Build option: define SERIALIZER_PARITY_EN to append an even-parity bit
// (XOR of the captured word) after dst<WIDTH-1>, making WIDTH+1 bits per word.
module result_serializer
    import compressor_bench_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = cnt_width(WIDTH)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_dst,
    input  logic             i_start,
    output logic             o_busy,
    output logic             o_ser_out,
    output logic             o_ser_valid,
    input  logic             i_ser_ready,
    output logic             o_done
);

`ifdef SERIALIZER_PARITY_EN
    // Parity rides in an extra top bit of the shift register, so it is
    // captured together with the word and falls out last.
    localparam int SR_W   = WIDTH + 1;
    localparam int LAST_I = WIDTH;
`else
    localparam int SR_W   = WIDTH;
    localparam int LAST_I = WIDTH - 1;
`endif

    // Index of the final bit; cnt stops here, it never wraps.
    localparam logic [CNT_W-1:0] LAST = CNT_W'(LAST_I);

    logic [1:0]       r_state;
    logic [SR_W-1:0]  r_shreg;
    logic [CNT_W-1:0] r_cnt;

    logic             w_hs;
    logic [SR_W-1:0]  w_load;

    assign w_hs = (r_state == S_SHIFT) && i_ser_ready;

`ifdef SERIALIZER_PARITY_EN
    assign w_load = {^i_dst, i_dst};
`else
    assign w_load = i_dst;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_shreg <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_shreg <= w_load;
                        r_cnt   <= '0;
                        r_state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (w_hs) begin
                        if (r_cnt == LAST) begin
                            r_state <= S_DONE;
                        end else begin
                            r_shreg <= r_shreg >> 1;
                            r_cnt   <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // All outputs decode directly from registers, so they are glitch-free
    // and stay put across stalls.
    assign o_busy      = (r_state == S_SHIFT) || (r_state == S_DONE);
    assign o_ser_valid = (r_state == S_SHIFT);
    assign o_ser_out   = (r_state == S_SHIFT) && r_shreg[0];
    assign o_done      = (r_state == S_DONE);

endmodule

// File: tb/tb_result_serializer.sv
// Scoreboard bench for result_serializer: stimulus pushes expected serial
// bits and done markers into a queue; a negedge monitor pops and compares.
module tb_result_serializer;
    import compressor_bench_pkg::*;

    localparam int W = DEFAULT_WIDTH;
`ifdef SERIALIZER_PARITY_EN
    localparam int NB = W + 1;
`else
    localparam int NB = W;
`endif
    localparam int DONE_MARK = 2;
    localparam int TMO       = 300;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] dst;
    logic         start;
    logic         busy;
    logic         ser_out;
    logic         ser_valid;
    logic         ser_ready;
    logic         done;

    int n_vec = 0;
    int n_err = 0;
    int exp_q[$];

    logic held_v   = 1'b0;
    logic held_bit = 1'b0;

    always #5 clk = ~clk;

    result_serializer #(.WIDTH(W)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_dst       (dst),
        .i_start     (start),
        .o_busy      (busy),
        .o_ser_out   (ser_out),
        .o_ser_valid (ser_valid),
        .i_ser_ready (ser_ready),
        .o_done      (done)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Expected stream for word d: first n bits (LSB-first, parity appended
    // when enabled), optionally followed by one done pulse.
    task automatic push_word(input logic [W-1:0] d, input int n, input bit with_done);
        logic [NB-1:0] full;
`ifdef SERIALIZER_PARITY_EN
        full = {^d, d};
`else
        full = d;
`endif
        for (int i = 0; i < n; i++) exp_q.push_back(int'(full[i]));
        if (with_done) exp_q.push_back(DONE_MARK);
    endtask

    // Monitor: checks every accepted bit, every done pulse, and that a
    // stalled bit is unchanged on the next valid cycle.
    always @(negedge clk) begin
        if (rst) begin
            held_v = 1'b0;
        end else begin
            if (held_v && ser_valid) chk("stall_hold", int'(ser_out), int'(held_bit));
            if (ser_valid && ser_ready) begin
                if (exp_q.size() == 0) chk("unexpected_bit", int'(ser_out), -1);
                else chk("ser_bit", int'(ser_out), exp_q.pop_front());
            end
            if (done) begin
                if (exp_q.size() == 0) chk("unexpected_done", 1, -1);
                else chk("done_order", DONE_MARK, exp_q.pop_front());
            end
            held_v   = ser_valid && !ser_ready;
            held_bit = ser_out;
        end
    end

    // Called just after a posedge. mode 0: ready high; 1: ready 1,0,0,1
    // repeating; 2: ready high plus a start/dst=0 injection mid-transfer.
    // Returns the cycle (1 = first after capture) in which done was seen.
    task automatic xfer(input logic [W-1:0] d, input int mode, output int dcyc);
        int cyc;
        dcyc      = -1;
        dst       = d;
        start     = 1'b1;
        ser_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc   = 1;
        while (cyc < TMO) begin
            if (mode == 1) ser_ready = (((cyc - 1) % 4) == 0) || (((cyc - 1) % 4) == 3);
            if (mode == 2) begin
                start = (cyc == 5);
                if (cyc == 5) dst = '0;
            end
            @(negedge clk);
            if (done) begin
                dcyc = cyc;
                break;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start     = 1'b0;
        ser_ready = 1'b1;
        if (dcyc < 0) chk("done_timeout", dcyc, 0);
    endtask

    function automatic int toggle_done_cycle();
        int hs = 0;
        for (int c = 1; c < TMO; c++) begin
            if (((c - 1) % 4) == 0 || ((c - 1) % 4) == 3) hs++;
            if (hs == NB) return c + 1;
        end
        return -1;
    endfunction

    task automatic check_idle_next(input string name);
        @(posedge clk); #1;
        chk({name, "_busy"}, int'(busy), 0);
        chk({name, "_valid"}, int'(ser_valid), 0);
    endtask

    initial begin
        int dc;
        int t0;
        rst       = 1'b1;
        dst       = '0;
        start     = 1'b0;
        ser_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_ser_out", int'(ser_out), 0);
        chk("rst_ser_valid", int'(ser_valid), 0);
        chk("rst_done", int'(done), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Basic word, ready always high.
        push_word(19'h5A5A5, NB, 1'b1);
        xfer(19'h5A5A5, 0, dc);
        chk("basic_done_cycle", dc, NB + 1);
        check_idle_next("basic_after");

        // Same word with stalls.
        @(posedge clk); #1;
        push_word(19'h5A5A5, NB, 1'b1);
        xfer(19'h5A5A5, 1, dc);
        chk("stall_done_cycle", dc, toggle_done_cycle());
        check_idle_next("stall_after");

        // start/dst change mid-transfer must be ignored.
        @(posedge clk); #1;
        push_word(19'h5A5A5, NB, 1'b1);
        xfer(19'h5A5A5, 2, dc);
        chk("midstart_done_cycle", dc, NB + 1);
        check_idle_next("midstart_after");

        // Reset after the 7th accepted bit.
        @(posedge clk); #1;
        push_word(19'h5A5A5, 7, 1'b0);
        dst = 19'h5A5A5; start = 1'b1; ser_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) begin @(posedge clk); #1; end
        ser_ready = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_valid", int'(ser_valid), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_bits_consumed", exp_q.size(), 0);
        rst = 1'b0;
        ser_ready = 1'b1;
        repeat (NB + 3) begin
            @(negedge clk);
            chk("abort_no_done", int'(done), 0);
        end
        @(posedge clk); #1;
        push_word(19'h00001, NB, 1'b1);
        xfer(19'h00001, 0, dc);
        chk("after_abort_done_cycle", dc, NB + 1);
        check_idle_next("after_abort");

        // Back-to-back: second start in the IDLE cycle right after done.
        @(posedge clk); #1;
        push_word(19'h7FFFF, NB, 1'b1);
        push_word(19'h00000, NB, 1'b1);
        xfer(19'h7FFFF, 0, dc);
        t0 = dc + 1;
        @(posedge clk); #1;
        xfer(19'h00000, 0, dc);
        // Start cycle 0 .. second done cycle inclusive.
        chk("b2b_total_cycles", t0 + dc + 1, 2 * (NB + 2));
        check_idle_next("b2b_after");

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/result_serializer.md
Name: result_serializer

Overview:
- Parallel-to-serial unload stage for the compressor bench. It sits at the opposite end from the serial-in loading shift register.
- On `start`, it captures the compressor's parallel result bits (dst0..dst(WIDTH-1), packed LSB = dst0) into a shift register.
- It streams the captured bits out LSB-first on one serial line, using a valid/ready handshake, so a tester can read results through a single pin.
- It pulses `done` once the last bit has been accepted.

Parameters:
- WIDTH, 19, number of result bits captured and shifted out (must be >= 1).
- CNT_W, $clog2(WIDTH+1), width of the bit counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- dst  input  WIDTH  parallel compressor result; bit i is dst<i>.
- start  input  1  request to capture dst and begin a transfer.
- busy  output  1  high while a transfer is in progress (SHIFT or DONE state).
- ser_out  output  1  current serial bit.
- ser_valid  output  1  ser_out holds a valid bit.
- ser_ready  input  1  downstream accepts ser_out this cycle.
- done  output  1  one-cycle pulse after the final bit is accepted.

Behaviour:
- Reset: one clock; reset is synchronous and active-high.
  - rst=1 at a clock edge forces state=IDLE, shreg=0, cnt=0.
  - busy, ser_out, ser_valid and done are all 0 after reset.
  - Reset mid-transfer aborts the transfer: no done pulse, and the remaining bits are discarded.
- FSM states are IDLE, SHIFT and DONE.
- IDLE:
  - Outputs are busy=0, ser_valid=0, ser_out=0.
  - start=1 → shreg<=dst, cnt<=0, next state SHIFT.
  - Latency is 1: first bit is valid on the cycle after start.
- SHIFT:
  - busy=1, ser_valid=1, ser_out=shreg[0].
  - Outputs are registered/stable, and they hold while ser_ready=0 (no bit is lost or repeated).
  - A handshake occurs when ser_valid & ser_ready.
  - On a handshake with cnt < LAST: shreg<=shreg>>1, cnt<=cnt+1.
  - On a handshake with cnt == LAST: next state DONE.
  - LAST is WIDTH-1, or WIDTH when SERIALIZER_PARITY_EN is defined.
- DONE:
  - Lasts one cycle with done=1, busy=1, ser_valid=0; then returns to IDLE.
- start handling:
  - start is ignored in SHIFT and DONE.
  - dst is sampled only on the IDLE start edge; later dst changes do not affect an ongoing transfer.
- Back-to-back: start asserted in the cycle right after DONE (i.e. in IDLE) begins the next transfer.
  - Minimum cadence is WIDTH+2 cycles per word with ser_ready held high (one start cycle, WIDTH bits, one DONE cycle), plus one cycle with parity enabled.
- WIDTH=1: SHIFT lasts one handshake, then DONE.
- cnt never exceeds LAST; there is no wrap-around.

Optional Feature:
- Macro SERIALIZER_PARITY_EN.
- Defined:
  - An even-parity bit (XOR of all captured dst bits, computed at capture and held in a register) is sent as an extra bit after dst<WIDTH-1>.
  - The transfer is WIDTH+1 bits.
- Undefined:
  - Exactly WIDTH bits are sent, and no parity logic is present.

Decomposition:
- Shared package `compressor_bench_pkg`:
  - FSM state enum (S_IDLE, S_SHIFT, S_DONE).
  - Default result width constant (19).
  - Helper function for the counter width.
- No sub-module is needed beyond the FSM plus shift register. Parity is one XOR-reduce inside the module under the macro.

Test Plan:
- Reset, then dst=19'h5A5A5, start 1 cycle, ser_ready=1 → ser_out sequence 1,0,1,0,0,1,0,1,1,0,1,0,0,1,0,1,1,0,1 on 19 consecutive cycles, done pulse on cycle 20 after start, busy low on cycle 21.
- Same word, ser_ready toggled 1,0,0,1… → each bit held stable across stalls; the sequence is identical to the scenario above; done arrives only after the 19th handshake.
- dst changed to 0 and start re-pulsed mid-transfer → ignored; the original 19'h5A5A5 bits are completed and exactly one done pulse occurs.
- rst asserted after the 7th bit → next cycle ser_valid=0, busy=0, done never pulses; a new start with dst=19'h00001 yields 1 then 18 zeros.
- Two back-to-back transfers (19'h7FFFF, then start in the IDLE cycle after done with 19'h00000) → 19 ones, done, 19 zeros, done; total 42 cycles.
- With SERIALIZER_PARITY_EN defined, dst=19'h7FFFF → 19 ones then parity bit 1; dst=19'h5A5A5 → parity bit 0; done after the 20th handshake.
